// File: rtl/mxv_stream_engine_pkg.sv
// Shared defaults, element/accumulator types and FSM encoding for the
// matrix-vector stream engine.
package mxv_stream_engine_pkg;

  localparam int MXV_DW    = 8;
  localparam int MXV_MAX_N = 8;
  localparam int MXV_LANES = 2;
  localparam int MXV_ACC_W = 2 * MXV_DW + $clog2(MXV_MAX_N);

  typedef logic [MXV_DW-1:0]    elem_t;
  typedef logic [MXV_ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    LOAD,
    MAC,
    DRAIN
  } mxv_state_t;

endpackage

// File: rtl/mxv_stream_engine_lane.sv
// One unsigned multiply-accumulator. While en is high it adds a*b each cycle.
// clr restarts the sum from this cycle's product.
module mxv_stream_engine_lane #(
  parameter int DW    = 8,
  parameter int ACC_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);

  logic [2*DW-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (rst)     acc <= '0;
    else if (en) acc <= (clr ? '0 : acc) + ACC_W'(prod);
  end

endmodule

// File: rtl/mxv_stream_engine.sv
// Matrix-vector engine: loads A (row-major) and B, computes LANES rows per
// group in N MAC cycles, then streams y[] out in row order.
//   state | meaning
//   LOAD  | accepting A/B elements, N may be reconfigured while empty
//   MAC   | N accumulate cycles for the current row group
//   DRAIN | presenting the group's enabled lane results one by one
module mxv_stream_engine
  import mxv_stream_engine_pkg::*;
#(
  parameter  int DW    = MXV_DW,
  parameter  int MAX_N = MXV_MAX_N,
  parameter  int LANES = MXV_LANES,
  localparam int NW    = $clog2(MAX_N + 1),
  localparam int ACC_W = 2 * DW + $clog2(MAX_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    n_in,
  input  logic             n_load,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [DW-1:0]    a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [DW-1:0]    b_data,
  input  logic             b_keep,
  input  logic             clear,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_last,
  output logic             busy,
  output logic             a_full,
  output logic             b_full,
  output logic             cfg_err
);

  localparam int CW  = $clog2(MAX_N * MAX_N + 1);
  localparam int IW  = CW + 1;
  localparam int AIW = $clog2(MAX_N * MAX_N);
  localparam int BIW = $clog2(MAX_N);
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;

  mxv_state_t       state_q, state_d;
  logic [NW-1:0]    n_q, n_nxt, k_q;
  logic [CW-1:0]    a_cnt, a_cnt_nxt, n_sq;
  logic [NW-1:0]    b_cnt, b_cnt_nxt;
  logic [IW-1:0]    row_q;
  logic [LW-1:0]    d_q;
  logic             cfg_err_q;
  logic             rst_all, a_fire, b_fire, cfg_win, n_ok, start;
  logic             drain, grp_last, mac_done;
  logic [DW-1:0]    a_mem [MAX_N*MAX_N];
  logic [DW-1:0]    b_mem [MAX_N];
  logic [DW-1:0]    b_op;
  logic [ACC_W-1:0] acc [LANES];

  assign rst_all   = rst || clear;
  assign n_sq      = CW'(n_q) * CW'(n_q);
  assign a_full    = (a_cnt == n_sq);
  assign b_full    = (b_cnt == n_q);
  assign a_ready   = (state_q == LOAD) && !a_full;
  assign b_ready   = (state_q == LOAD) && !b_full;
  assign a_fire    = a_valid && a_ready;
  assign b_fire    = b_valid && b_ready;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q != LOAD);

  assign cfg_win   = n_load && (state_q == LOAD) && (a_cnt == '0) && (b_cnt == '0);
  assign n_ok      = (n_in != '0) && (n_in <= NW'(MAX_N));
  assign n_nxt     = (cfg_win && n_ok) ? n_in : n_q;
  assign a_cnt_nxt = a_cnt + CW'(a_fire);
  assign b_cnt_nxt = b_cnt + NW'(b_fire);
  // Look ahead one cycle so MAC begins right after the completing element.
  assign start     = (a_cnt_nxt == CW'(n_nxt) * CW'(n_nxt)) && (b_cnt_nxt == n_nxt);
  assign mac_done  = (k_q == n_q - NW'(1));

  assign drain     = (state_q == DRAIN);
  assign res_valid = drain;
  assign res_data  = drain ? acc[d_q] : '0;
  assign res_last  = drain && ((row_q + IW'(d_q)) == IW'(n_q) - IW'(1));
  assign grp_last  = (d_q == LW'(LANES - 1)) || res_last;
  assign b_op      = b_mem[k_q[BIW-1:0]];

  always_ff @(posedge clk) begin
    if (a_fire) a_mem[a_cnt[AIW-1:0]] <= a_data;
    if (b_fire) b_mem[b_cnt[BIW-1:0]] <= b_data;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IW-1:0] row;
    logic          row_en;
    logic [DW-1:0] a_op;

    assign row    = row_q + IW'(l);
    assign row_en = (row < IW'(n_q));
    // Rows past N feed zero; their results are never presented.
    assign a_op   = row_en ? a_mem[AIW'(row * IW'(n_q) + IW'(k_q))] : '0;

    mxv_stream_engine_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk (clk),
      .rst (rst_all),
      .clr (k_q == '0),
      .en  (state_q == MAC),
      .a   (a_op),
      .b   (b_op),
      .acc (acc[l])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (start) state_d = MAC;
      MAC:     if (mac_done) state_d = DRAIN;
      DRAIN:   if (res_ready && grp_last) state_d = res_last ? LOAD : MAC;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_all) begin
      state_q   <= LOAD;
      n_q       <= NW'(MAX_N);
      a_cnt     <= '0;
      b_cnt     <= '0;
      k_q       <= '0;
      row_q     <= '0;
      d_q       <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_win) begin
        if (n_ok) n_q <= n_in;
        else      cfg_err_q <= 1'b1;
      end
      case (state_q)
        LOAD: begin
          a_cnt <= a_cnt_nxt;
          b_cnt <= b_cnt_nxt;
          k_q   <= '0;
          row_q <= '0;
          d_q   <= '0;
        end
        MAC: k_q <= mac_done ? '0 : k_q + NW'(1);
        DRAIN: begin
          if (res_ready) begin
            if (grp_last) begin
              d_q   <= '0;
              row_q <= row_q + IW'(LANES);
              if (res_last) begin
                a_cnt <= '0;
                if (!b_keep) b_cnt <= '0;
              end
            end else begin
              d_q <= d_q + LW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_stream_engine.sv
// Directed bench for mxv_stream_engine at DW=8, MAX_N=8, LANES=2 with
// hand-computed result vectors.
module tb_mxv_stream_engine;

  localparam int DW    = 8;
  localparam int MAX_N = 8;
  localparam int NW    = 4;
  localparam int ACC_W = 19;

  logic             clk = 1'b0;
  logic             rst, n_load, a_valid, b_valid, b_keep, clear, res_ready;
  logic [NW-1:0]    n_in;
  logic [DW-1:0]    a_data, b_data;
  logic             a_ready, b_ready, res_valid, res_last, busy, a_full, b_full, cfg_err;
  logic [ACC_W-1:0] res_data;

  int checks = 0;
  int errors = 0;
  int a_vec [64];
  int b_vec [8];
  int y_exp [8];

  always #5 clk = ~clk;

  mxv_stream_engine #(.DW(DW), .MAX_N(MAX_N), .LANES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .n_in      (n_in),
    .n_load    (n_load),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .b_keep    (b_keep),
    .clear     (clear),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_last  (res_last),
    .busy      (busy),
    .a_full    (a_full),
    .b_full    (b_full),
    .cfg_err   (cfg_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_n(input int n);
    n_load = 1'b1;
    n_in   = NW'(n);
    step();
    n_load = 1'b0;
  endtask

  // Presents A and B elements in parallel until na/nb have been accepted.
  task automatic load(input int na, input int nb);
    int   ia, ib, guard;
    logic fa, fb;
    ia = 0; ib = 0; guard = 0;
    while ((ia < na || ib < nb) && guard < 200) begin
      a_valid = (ia < na);
      b_valid = (ib < nb);
      if (ia < na) a_data = DW'(a_vec[ia]);
      if (ib < nb) b_data = DW'(b_vec[ib]);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      step();
      if (fa) ia++;
      if (fb) ib++;
      guard++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("load_bound", 32'(guard < 200), 32'd1);
  endtask

  task automatic wait_res(input string tag, input int exp_lat);
    int cnt;
    cnt = 0;
    while (!res_valid && cnt < 100) begin
      step();
      cnt++;
    end
    chk(tag, 32'(cnt), 32'(exp_lat));
  endtask

  // Accepts n results, optionally stalling 5 cycles before result stall_at.
  task automatic drain(input int n, input int stall_at, input logic keep);
    int cnt;
    for (int i = 0; i < n; i++) begin
      cnt = 0;
      while (!res_valid && cnt < 100) begin
        step();
        cnt++;
      end
      chk("res_valid", 32'(res_valid), 32'd1);
      if (i == stall_at) begin
        res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          chk("stall_valid", 32'(res_valid), 32'd1);
          chk("stall_data", 32'(res_data), 32'(y_exp[i]));
          chk("stall_a_ready", 32'(a_ready), 32'd0);
        end
        res_ready = 1'b1;
      end
      chk($sformatf("y%0d", i), 32'(res_data), 32'(y_exp[i]));
      chk($sformatf("last%0d", i), 32'(res_last), 32'(i == n - 1));
      if (i == n - 1) b_keep = keep;
      step();
      b_keep = 1'b0;
    end
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_a_ready", 32'(a_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; n_load = 1'b0; n_in = '0; a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0; b_keep = 1'b0; clear = 1'b0; res_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_full", 32'({a_full, b_full}), 32'd0);

    // N=2: y = {1*5+2*6, 3*5+4*6}
    set_n(2);
    a_vec[0] = 1; a_vec[1] = 2; a_vec[2] = 3; a_vec[3] = 4;
    b_vec[0] = 5; b_vec[1] = 6;
    y_exp[0] = 17; y_exp[1] = 39;
    load(4, 2);
    chk("mac_a_full", 32'(a_full), 32'd1);
    chk("mac_b_full", 32'(b_full), 32'd1);
    chk("mac_busy", 32'(busy), 32'd1);
    chk("mac_a_ready", 32'(a_ready), 32'd0);
    wait_res("lat_n2", 2);
    drain(2, -1, 1'b0);
    chk("n2_b_full", 32'(b_full), 32'd0);

    // N=3 tail group: second group only has row 2
    set_n(3);
    for (int i = 0; i < 9; i++) a_vec[i] = i + 1;
    for (int i = 0; i < 3; i++) b_vec[i] = 1;
    y_exp[0] = 6; y_exp[1] = 15; y_exp[2] = 24;
    load(9, 3);
    wait_res("lat_n3", 3);
    drain(3, -1, 1'b0);

    // N=8 all 255 with a mid-drain stall, keeping B afterwards
    set_n(8);
    for (int i = 0; i < 64; i++) a_vec[i] = 255;
    for (int i = 0; i < 8; i++) b_vec[i] = 255;
    for (int i = 0; i < 8; i++) y_exp[i] = 520200;
    load(64, 8);
    wait_res("lat_n8", 8);
    drain(8, 3, 1'b1);
    chk("keep_b_full", 32'(b_full), 32'd1);
    chk("keep_b_ready", 32'(b_ready), 32'd0);
    chk("keep_a_full", 32'(a_full), 32'd0);

    // Second run reuses B=255: y = 8*2*255
    for (int i = 0; i < 64; i++) a_vec[i] = 2;
    for (int i = 0; i < 8; i++) y_exp[i] = 4080;
    load(64, 0);
    wait_res("lat_keep", 8);
    drain(8, -1, 1'b0);
    chk("nokeep_b_full", 32'(b_full), 32'd0);

    // Illegal dimensions leave N=2 in place
    set_n(2);
    chk("cfg_ok", 32'(cfg_err), 32'd0);
    set_n(0);
    chk("cfg_zero", 32'(cfg_err), 32'd1);
    set_n(9);
    chk("cfg_big", 32'(cfg_err), 32'd1);
    a_vec[0] = 2; a_vec[1] = 0; a_vec[2] = 0; a_vec[3] = 3;
    b_vec[0] = 7; b_vec[1] = 1;
    y_exp[0] = 14; y_exp[1] = 3;
    load(4, 2);
    wait_res("lat_cfg", 2);
    drain(2, -1, 1'b0);
    chk("cfg_sticky", 32'(cfg_err), 32'd1);

    // clear in the first MAC cycle
    load(4, 2);
    chk("pre_clear_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_res_valid", 32'(res_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_cfg_err", 32'(cfg_err), 32'd0);
    chk("clr_a_ready", 32'(a_ready), 32'd1);
    chk("clr_full", 32'({a_full, b_full}), 32'd0);

    // n_load to 1 together with the only A and B elements: y = 7*6
    n_load = 1'b1; n_in = NW'(1);
    a_valid = 1'b1; a_data = 8'd7;
    b_valid = 1'b1; b_data = 8'd6;
    step();
    n_load = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    chk("n1_busy", 32'(busy), 32'd1);
    y_exp[0] = 42;
    wait_res("lat_n1", 1);
    drain(1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mxv_stream_engine.md
# mxv_stream_engine

Parametrised matrix-vector multiply engine, the next generation of the UART-driven processor datapath. It accepts an N×N matrix A (row-major) and an N-vector B over two valid/ready load streams, with N runtime-configurable up to MAX_N. It computes LANES rows in parallel and streams the N results out through a valid/ready port. It sits between the UART command decoder and the UART transmitter, replacing the fixed-size FIFO/processor pair.

## Interface
Parameters:
- DW, 8, element width (unsigned)
- MAX_N, 8, maximum matrix dimension (≥2)
- LANES, 2, rows computed concurrently (1..MAX_N)
- NW (derived), $clog2(MAX_N+1), width of N
- ACC_W (derived), 2*DW+$clog2(MAX_N), result width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous and active-high
- n_in  in  NW  requested dimension
- n_load  in  1  latch n_in as N
- a_valid / a_ready  in/out  1  matrix load handshake
- a_data  in  DW  matrix element, row-major
- b_valid / b_ready  in/out  1  vector load handshake
- b_data  in  DW  vector element
- b_keep  in  1  retain B for the next operation
- clear  in  1  synchronous flush
- res_valid / res_ready  out/in  1  result handshake
- res_data  out  ACC_W  result element y[i]
- res_last  out  1  marks y[N-1]
- busy  out  1  high in MAC or DRAIN
- a_full, b_full  out  1  A count == N*N, B count == N
- cfg_err  out  1  sticky; set by an illegal n_load

## Operation
- States:
  - LOAD → MAC when a_full && b_full.
  - MAC → DRAIN after N cycles.
  - DRAIN → MAC for the next row group, or → LOAD after y[N-1] is accepted.
- Reset/clear: state LOAD, A/B counts 0, N=MAX_N, cfg_err=0. All outputs 0 except a_ready=b_ready=1.
- n_load in LOAD with counts both 0 and 1≤n_in≤MAX_N: N←n_in.
  - n_in=0 or n_in>MAX_N: N unchanged, cfg_err←1.
  - n_load at any other time: ignored, no error.
- a_ready = (state==LOAD)&&!a_full. b_ready likewise with b_full. A and B load independently and interleave freely.
- MAC: for row group g, lane l handles row r=g*LANES+l. On cycle k (0..N-1): acc[l] += A[r][k]*B[k], with acc cleared on MAC entry. Lanes with r≥N are disabled.
- DRAIN: outputs lane results in ascending row order, skipping disabled lanes.
  - res_data/res_valid stay stable until res_ready.
  - res_last=1 only with y[N-1].
- Arithmetic is unsigned, full precision. ACC_W guarantees no overflow.
- On completion, A count←0.
  - b_keep sampled high on the y[N-1] handshake cycle: B and its count are retained, so b_full stays 1 and only a new A is needed.
  - Otherwise B count←0.
- clear in any state wins over every other event that cycle. Any in-flight result is dropped and res_valid falls the next cycle. cfg_err is cleared only by rst or clear.

## Timing
- Load acceptance: element written on the cycle valid&&ready. The count is updated the next cycle. a_full rises the cycle after the N*N-th acceptance.
- Latency: the last accepted load element (the one completing a_full&&b_full) at cycle t gives MAC from t+1 to t+N and first res_valid at t+N+1.
- Per group: N MAC cycles, plus one result per accepted handshake. Backpressure stalls DRAIN only.
- Next group MAC starts the cycle after its last result is accepted. LOAD is re-entered the cycle after y[N-1] is accepted, with a_ready high that cycle.
- busy is high from the first MAC cycle through the y[N-1] handshake cycle.
- Simultaneous n_load and a load handshake in LOAD with counts 0: N updates and the element is accepted against the new N.

## Structure
- global_pkg gains: MXV_DW, MXV_MAX_N, MXV_LANES defaults; elem_t, acc_t typedefs; mxv_state_t enum {LOAD, MAC, DRAIN}.
- Sub-module mxv_lane: one multiply-accumulator with clear/enable, instantiated LANES times.
- A stored as MAX_N*MAX_N registers and B as MAX_N registers, both indexed by counters. No RAM macro.

## Test plan
- N=2, LANES=2: A={1,2,3,4}, B={5,6} → y={17,39}. res_last on 39. First res_valid 3 cycles after the last load.
- N=3, LANES=2 (tail group): A=1..9, B={1,1,1} → y={6,15,24}. Lane 1 is disabled in group 1.
- N=MAX_N=8, all elements 255 → every y=520200. No overflow at ACC_W=19.
- Backpressure: hold res_ready low 5 cycles mid-DRAIN → res_data stable, no loss. a_ready stays 0 until y[N-1] is accepted.
- b_keep=1 on completion → second run needs only A. b_full stays 1, with correct results against the old B.
- n_load n_in=0, then n_in=9 (MAX_N=8) → cfg_err=1 and N unchanged. clear mid-MAC → LOAD next cycle with res_valid=0 and cfg_err=0.
